// File: rtl/hvsync_timing_core_if.sv
// Purpose : raster timing bundle carrying the beam position and sync decodes.
// Signals : hsync, vsync  - active-high sync pulses
//           display_on    - beam inside the visible area
//           hpos, vpos    - current horizontal / vertical counters (10 bits)
// Modports: master drives the bundle (timing core), slave observes it.
interface hvsync_timing_core_if;

  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;

  modport master (
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos
  );

  modport slave (
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos
  );

endinterface : hvsync_timing_core_if

// File: rtl/hvsync_timing_core.sv
// Purpose : VGA-style horizontal/vertical timing generator. Two registered
//           counters walk the raster; sync and visible-area flags are decoded
//           from the counter registers with zero latency.
// Ports   : clk    - pixel clock, all state updates on its rising edge
//           reset  - asynchronous active-low reset (0 = in reset)
//           vga    - master side of hvsync_timing_core_if
//                    (hsync, vsync, display_on, hpos, vpos)
// Totals above 1024 per axis are not supported; counters are 10 bits wide.
module hvsync_timing_core #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  hvsync_timing_core_if.master vga
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Decode boundaries, pre-sized to the counter width.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] r_hpos;
  logic [CNT_W-1:0] r_vpos;
  logic [CNT_W-1:0] w_hpos_nxt;
  logic [CNT_W-1:0] w_vpos_nxt;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_h_vis;
  logic             w_v_vis;

  // Next-position logic: hpos wraps at end of line, vpos steps only on that wrap.
  always_comb begin
    w_h_last   = (r_hpos == H_LAST);
    w_v_last   = (r_vpos == V_LAST);
    w_hpos_nxt = r_hpos + CNT_W'(1);
    w_vpos_nxt = r_vpos;
    if (w_h_last) begin
      w_hpos_nxt = '0;
      w_vpos_nxt = w_v_last ? '0 : (r_vpos + CNT_W'(1));
    end
  end

  // Position counters; async clear so a mid-frame reset drops syncs at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else begin
      r_hpos <= w_hpos_nxt;
      r_vpos <= w_vpos_nxt;
    end
  end

  // Zero-latency decodes from the counter registers.
  always_comb begin
    w_hsync = (r_hpos >= HS_START) && (r_hpos < HS_END);
    w_vsync = (r_vpos >= VS_START) && (r_vpos < VS_END);
    w_h_vis = (r_hpos < H_VIS_END);
    w_v_vis = (r_vpos < V_VIS_END);
  end

  // display_on is gated by reset because (0,0) is itself a visible position.
  assign vga.hsync      = w_hsync;
  assign vga.vsync      = w_vsync;
  assign vga.display_on = reset & w_h_vis & w_v_vis;
  assign vga.hpos       = r_hpos;
  assign vga.vpos       = r_vpos;

endmodule : hvsync_timing_core

// File: tb/tb_hvsync_timing_core.sv
// Directed bench: a default-timing instance for line-level checks and a
// small-timing instance (15 x 10 raster) for whole-frame and wrap checks.
module tb_hvsync_timing_core;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hvsync_timing_core_if u_if_d ();
  hvsync_timing_core_if u_if_s ();

  hvsync_timing_core u_dut_d (
    .clk   (clk),
    .reset (reset),
    .vga   (u_if_d.master)
  );

  // Small raster: H 8+2+3+2 = 15 (hsync 10..12), V 6+1+2+1 = 10 (vsync 7..8).
  hvsync_timing_core #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .vga   (u_if_s.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_d_hpos"}, 32'(u_if_d.hpos), 32'd0);
    check({pfx, "_d_vpos"}, 32'(u_if_d.vpos), 32'd0);
    check({pfx, "_d_hs"},   32'(u_if_d.hsync), 32'd0);
    check({pfx, "_d_vs"},   32'(u_if_d.vsync), 32'd0);
    check({pfx, "_d_de"},   32'(u_if_d.display_on), 32'd0);
    check({pfx, "_s_hpos"}, 32'(u_if_s.hpos), 32'd0);
    check({pfx, "_s_vpos"}, 32'(u_if_s.vpos), 32'd0);
    check({pfx, "_s_hs"},   32'(u_if_s.hsync), 32'd0);
    check({pfx, "_s_vs"},   32'(u_if_s.vsync), 32'd0);
    check({pfx, "_s_de"},   32'(u_if_s.display_on), 32'd0);
  endtask

  initial begin
    int   hs_cnt;
    int   vs_cnt;
    int   de_cnt;
    int   rise_at;
    int   fall_at;
    int   eh;
    int   ev;
    logic prev_hs;

    // Held in reset across several edges: everything stays at zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");

    // Release between edges: (0,0) is visible immediately.
    reset = 1'b1;
    #1;
    check("rel_de", 32'(u_if_d.display_on), 32'd1);

    // One full default line, sampled once per clock.
    hs_cnt  = 0;
    de_cnt  = 0;
    rise_at = -1;
    fall_at = -1;
    prev_hs = 1'b0;
    for (int n = 0; n < 800; n++) begin
      check("line_hpos", 32'(u_if_d.hpos), 32'(n));
      check("line_vpos", 32'(u_if_d.vpos), 32'd0);
      check("line_hs",   32'(u_if_d.hsync), 32'(n >= 656 && n < 752));
      check("line_de",   32'(u_if_d.display_on), 32'(n < 640));
      if (u_if_d.hsync) hs_cnt++;
      if (u_if_d.display_on) de_cnt++;
      if (u_if_d.hsync && !prev_hs && rise_at < 0) rise_at = n;
      if (!u_if_d.hsync && prev_hs && fall_at < 0) fall_at = n;
      prev_hs = u_if_d.hsync;
      @(negedge clk);
    end
    check("wrap_hpos", 32'(u_if_d.hpos), 32'd0);
    check("wrap_vpos", 32'(u_if_d.vpos), 32'd1);
    check("hs_width",  32'(hs_cnt), 32'd96);
    check("hs_rise",   32'(rise_at), 32'd656);
    check("hs_fall",   32'(fall_at), 32'd752);
    check("de_line",   32'(de_cnt), 32'd640);

    // Move into the hsync pulse of line 1, then reset without a clock edge.
    repeat (700) @(negedge clk);
    check("pre_hpos", 32'(u_if_d.hpos), 32'd700);
    check("pre_vpos", 32'(u_if_d.vpos), 32'd1);
    check("pre_hs",   32'(u_if_d.hsync), 32'd1);
    check("pre_de",   32'(u_if_d.display_on), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    check("hold_hpos", 32'(u_if_d.hpos), 32'd0);
    reset = 1'b1;
    #1;

    // One full small frame; expected position derived from the cycle index.
    hs_cnt = 0;
    vs_cnt = 0;
    de_cnt = 0;
    for (int n = 0; n < 150; n++) begin
      eh = n % 15;
      ev = n / 15;
      check("frm_hpos", 32'(u_if_s.hpos), 32'(eh));
      check("frm_vpos", 32'(u_if_s.vpos), 32'(ev));
      check("frm_hs",   32'(u_if_s.hsync), 32'(eh >= 10 && eh < 13));
      check("frm_vs",   32'(u_if_s.vsync), 32'(ev >= 7 && ev < 9));
      check("frm_de",   32'(u_if_s.display_on), 32'(eh < 8 && ev < 6));
      if (u_if_s.hsync) hs_cnt++;
      if (u_if_s.vsync) vs_cnt++;
      if (u_if_s.display_on) de_cnt++;
      @(negedge clk);
    end
    // Past the last pixel (14,9): frame restarts at (0,0) with its decodes.
    check("bnd_hpos", 32'(u_if_s.hpos), 32'd0);
    check("bnd_vpos", 32'(u_if_s.vpos), 32'd0);
    check("bnd_hs",   32'(u_if_s.hsync), 32'd0);
    check("bnd_vs",   32'(u_if_s.vsync), 32'd0);
    check("bnd_de",   32'(u_if_s.display_on), 32'd1);
    check("frm_vs_cnt", 32'(vs_cnt), 32'd30);
    check("frm_hs_cnt", 32'(hs_cnt), 32'd30);
    check("frm_de_cnt", 32'(de_cnt), 32'd48);
    check("d_hpos_150", 32'(u_if_d.hpos), 32'd150);

    // Small instance inside both sync pulses at (12,7), then async reset.
    repeat (117) @(negedge clk);
    check("s_pre_hpos", 32'(u_if_s.hpos), 32'd12);
    check("s_pre_vpos", 32'(u_if_s.vpos), 32'd7);
    check("s_pre_hs",   32'(u_if_s.hsync), 32'd1);
    check("s_pre_vs",   32'(u_if_s.vsync), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async2");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("s_rel_de",   32'(u_if_s.display_on), 32'd1);
    @(negedge clk);
    check("s_first_hpos", 32'(u_if_s.hpos), 32'd1);
    check("s_first_vpos", 32'(u_if_s.vpos), 32'd0);
    check("d_first_hpos", 32'(u_if_d.hpos), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hvsync_timing_core
